// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipeline writes pass straight through, long-latency results queue in a FIFO.
// Optional same-cycle bypass of an empty FIFO when WB_BYPASS_EN is defined.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_we,
    input  logic [AW-1:0]              pipe_waddr,
    input  logic [DW-1:0]              pipe_wdata,
    input  logic                       lu_valid,
    output logic                       lu_ready,
    input  logic [AW-1:0]              lu_waddr,
    input  logic [DW-1:0]              lu_wdata,
    input  logic                       iss_valid,
    input  logic [AW-1:0]              iss_waddr,
    output logic [(2**AW)-1:0]         busy,
    output logic [$clog2(DEPTH):0]     fifo_cnt,
    output logic                       we,
    output logic [AW-1:0]              waddr,
    output logic [DW-1:0]              wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]     memAddr [DEPTH];
    logic [DW-1:0]     memData [DEPTH];
    logic [PW-1:0]     rdPtr_q, wrPtr_q;
    logic [CW-1:0]     cnt_q;
    logic [(2**AW)-1:0] busy_q, busy_d;

    logic pipeGrant, accept, bypass, push, pop;

    assign pipeGrant = pipe_we && (pipe_waddr != '0);
    assign lu_ready  = (cnt_q != FULL) && !rst;
    assign accept    = lu_valid && lu_ready && (lu_waddr != '0);
    assign pop       = !rst && !pipeGrant && (cnt_q != '0);

`ifdef WB_BYPASS_EN
    assign bypass = (cnt_q == '0) && !pipeGrant && accept;
`else
    assign bypass = 1'b0;
`endif

    assign push     = accept && !bypass;
    assign busy     = busy_q;
    assign fifo_cnt = cnt_q;

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (pipeGrant && !rst) begin
            we    = 1'b1;
            waddr = pipe_waddr;
            wdata = pipe_wdata;
        end else if (pop) begin
            we    = 1'b1;
            waddr = memAddr[rdPtr_q];
            wdata = memData[rdPtr_q];
        end else if (bypass) begin
            we    = 1'b1;
            waddr = lu_waddr;
            wdata = lu_wdata;
        end
    end

    // Clears are applied before the issue set so a same-register set wins.
    always_comb begin
        busy_d = busy_q;
        if (pop)
            busy_d[memAddr[rdPtr_q]] = 1'b0;
        if (bypass)
            busy_d[lu_waddr] = 1'b0;
        if (iss_valid && (iss_waddr != '0))
            busy_d[iss_waddr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            memAddr[wrPtr_q] <= lu_waddr;
            memData[wrPtr_q] <= lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            if (push)
                wrPtr_q <= wrPtr_q + PW'(1);
            if (pop)
                rdPtr_q <= rdPtr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            busy_q <= busy_d;
        end
    end

endmodule
